// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Request-driven burst sequencer for the 4x8 RAM (two 2x8 halves). Accepts
// 1-4 beat read/write bursts over valid/ready, drives the RAM R_W/ADDR/DATA_IN
// pins, and captures combinational RAM read data into a backpressured output
// register. Burst addresses wrap modulo 2^AW.
//
// Optional feature: define RAM_BURST_WRITE_VERIFY_EN to read back every
// written beat for one cycle (VERIFY) and flag mismatches on o_verify_err.
// With the macro undefined there is no VERIFY state and o_verify_err is 0.
module ram_burst_ctrl #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_clr,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_write,
   input  logic [AW-1:0] i_req_addr,
   input  logic [1:0]    i_req_len,
   input  logic          i_wdata_valid,
   output logic          o_wdata_ready,
   input  logic [DW-1:0] i_wdata,
   output logic          o_rdata_valid,
   input  logic          i_rdata_ready,
   output logic [DW-1:0] o_rdata,
   output logic          o_done,
   output logic          o_verify_err,
   output logic          o_ram_rw,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_din,
   input  logic [DW-1:0] i_ram_dout
);

`ifdef RAM_BURST_WRITE_VERIFY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_READ   = 2'd2,
      S_VERIFY = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;
`endif

   state_t        r_state;
   logic [AW-1:0] r_cur_addr;
   logic [1:0]    r_remain;       // beats left after the current one
   logic [DW-1:0] r_rdata;
   logic          r_rdata_valid;
   logic          r_done;
`ifdef RAM_BURST_WRITE_VERIFY_EN
   logic          r_verify_err;
   logic [DW-1:0] r_wbeat;        // copy of the beat just written, for readback
`endif

   logic          w_req_fire;
   logic          w_capture;
   logic          w_last;
   logic [AW-1:0] w_addr_nxt;

   // A pending read beat blocks new requests so the output register never
   // has to hold beats from two bursts.
   assign o_req_ready   = (r_state == S_IDLE) && !r_rdata_valid;
   assign w_req_fire    = i_req_valid && o_req_ready;

   // CLR gates the write strobe so a reset mid-burst stops writes that same edge.
   assign o_wdata_ready = (r_state == S_WRITE) && !i_clr;
   assign o_ram_rw      = o_wdata_ready && i_wdata_valid;
   assign o_ram_addr    = (r_state == S_IDLE) ? '0 : r_cur_addr;
   assign o_ram_din     = (r_state == S_WRITE) ? i_wdata : '0;

   assign w_capture     = (r_state == S_READ) && (!r_rdata_valid || i_rdata_ready);
   assign w_last        = (r_remain == 2'd0);
   assign w_addr_nxt    = r_cur_addr + 1'b1;

   assign o_rdata_valid = r_rdata_valid;
   assign o_rdata       = r_rdata;
   assign o_done        = r_done;
`ifdef RAM_BURST_WRITE_VERIFY_EN
   assign o_verify_err  = r_verify_err;
`else
   assign o_verify_err  = 1'b0;
`endif

   // Burst sequencer: request capture, beat counting, read capture, done pulse.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state       <= S_IDLE;
         r_cur_addr    <= '0;
         r_remain      <= 2'd0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_done        <= 1'b0;
`ifdef RAM_BURST_WRITE_VERIFY_EN
         r_verify_err  <= 1'b0;
         r_wbeat       <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         // Consumer drain; a capture below in the same cycle overrides this.
         if (r_rdata_valid && i_rdata_ready)
            r_rdata_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_cur_addr <= i_req_addr;
                  r_remain   <= i_req_len;
                  r_state    <= i_req_write ? S_WRITE : S_READ;
`ifdef RAM_BURST_WRITE_VERIFY_EN
                  r_verify_err <= 1'b0;
`endif
               end
            end

            S_WRITE: begin
               if (i_wdata_valid) begin
`ifdef RAM_BURST_WRITE_VERIFY_EN
                  // Hold the address; VERIFY reads it back before advancing.
                  r_wbeat <= i_wdata;
                  r_state <= S_VERIFY;
`else
                  r_cur_addr <= w_addr_nxt;
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_remain <= r_remain - 2'd1;
                  end
`endif
               end
            end

`ifdef RAM_BURST_WRITE_VERIFY_EN
            S_VERIFY: begin
               if (i_ram_dout != r_wbeat)
                  r_verify_err <= 1'b1;
               r_cur_addr <= w_addr_nxt;
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_remain <= r_remain - 2'd1;
                  r_state  <= S_WRITE;
               end
            end
`endif

            S_READ: begin
               if (w_capture) begin
                  r_rdata       <= i_ram_dout;
                  r_rdata_valid <= 1'b1;
                  r_cur_addr    <= w_addr_nxt;
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_remain <= r_remain - 2'd1;
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural 4x8 RAM attached.
module tb_ram_burst_ctrl;

   logic       clk;
   logic       clr;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_addr;
   logic [1:0] req_len;
   logic       wdata_valid;
   logic       wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid;
   logic       rdata_ready;
   logic [7:0] rdata;
   logic       done;
   logic       verify_err;
   logic       ram_rw;
   logic [1:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;

   int checks = 0;
   int errors = 0;
   logic [7:0] rq[$];

   // RAM model
   logic [7:0] mem [4];
   logic       mem_init;
   logic       force_zero;

   ram_burst_ctrl #(.AW(2), .DW(8)) dut (
      .i_clk(clk), .i_clr(clr),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_len(req_len),
      .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
      .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
      .o_done(done), .o_verify_err(verify_err),
      .o_ram_rw(ram_rw), .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      end else if (ram_rw) begin
         mem[ram_addr] <= ram_din;
      end
   end

   assign ram_dout = force_zero ? 8'h00 : mem[ram_addr];

   task automatic issue(input logic wr, input logic [1:0] a, input logic [1:0] l);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
      #1;
      while (!req_ready && n < 10) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL req_accept got=%b exp=1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wr_burst(input logic [1:0] a, input logic [1:0] l, input logic [3:0][7:0] d,
                           input logic gaps, input logic [15:0] vmask, output int last_c);
      int b = 0;
      int c = 0;
      int dn = 0;
      int dlat = -1;
      int exp_dlat;
      logic [1:0] ea;
`ifdef RAM_BURST_WRITE_VERIFY_EN
      exp_dlat = 1;
`else
      exp_dlat = 0;
`endif
      ea = a;
      last_c = -1;
      issue(1'b1, a, l);
      while (b <= int'(l) && c < 16) begin
         @(negedge clk);
         wdata_valid = gaps ? vmask[c] : 1'b1;
         wdata = d[b];
         #1;
         if (done) dn++;
         checks++;
         if (wdata_valid && wdata_ready) begin
            if (ram_rw !== 1'b1 || ram_addr !== ea || ram_din !== d[b]) begin
               errors++;
               $display("FAIL write_beat%0d got rw=%b addr=%0d din=%h exp rw=1 addr=%0d din=%h",
                        b, ram_rw, ram_addr, ram_din, ea, d[b]);
            end
            ea++; b++; last_c = c;
         end else if (ram_rw !== 1'b0) begin
            errors++; $display("FAIL write_gap c=%0d got rw=%b exp=0", c, ram_rw);
         end
         c++;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         wdata_valid = 1'b0;
         #1;
         if (done) begin
            dn++;
            if (dlat < 0) dlat = k;
         end
      end
      checks++;
      if (b != int'(l) + 1) begin
         errors++; $display("FAIL write_beats got=%0d exp=%0d", b, int'(l) + 1);
      end
      checks++;
      if (dn != 1 || dlat != exp_dlat) begin
         errors++; $display("FAIL write_done got pulses=%0d lat=%0d exp pulses=1 lat=%0d", dn, dlat, exp_dlat);
      end
   endtask

   task automatic rd_burst(input logic [1:0] a, input logic [1:0] l, input logic [3:0][7:0] e,
                           input int stall_beat, input int stall_n);
      int c = 0;
      int taken = 0;
      int st = 0;
      int dn = 0;
      int first = -1;
      logic [7:0] exp_d;
      for (int i = 0; i <= int'(l); i++) rq.push_back(e[i]);
      issue(1'b0, a, l);
      while (rq.size() > 0 && c < 30) begin
         @(negedge clk);
         rdata_ready = !(taken == stall_beat && st < stall_n);
         #1;
         if (done) dn++;
         if (rdata_valid) begin
            if (first < 0) first = c;
            exp_d = rq[0];
            checks++;
            if (rdata !== exp_d || req_ready !== 1'b0 || ram_rw !== 1'b0) begin
               errors++;
               $display("FAIL read_beat%0d got data=%h req_ready=%b rw=%b exp data=%h req_ready=0 rw=0",
                        taken, rdata, req_ready, ram_rw, exp_d);
            end
            if (rdata_ready) begin
               void'(rq.pop_front());
               taken++;
            end else begin
               st++;
            end
         end
         c++;
      end
      checks++;
      if (rq.size() != 0 || first != 1) begin
         errors++; $display("FAIL read_timing got left=%0d first=%0d exp left=0 first=1", rq.size(), first);
      end
      rq.delete();
      @(negedge clk);
      rdata_ready = 1'b1;
      #1;
      if (done) dn++;
      checks++;
      if (dn != 1 || rdata_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL read_end got done=%0d rvalid=%b req_ready=%b exp done=1 rvalid=0 req_ready=1",
                  dn, rdata_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      clr = 1'b0; mem_init = 1'b0;
      #1;
      checks++;
      if (rdata_valid !== 1'b0 || rdata !== 8'h00 || done !== 1'b0 || verify_err !== 1'b0 ||
          req_ready !== 1'b1 || wdata_ready !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 2'd0) begin
         errors++;
         $display("FAIL reset_state got rv=%b rd=%h done=%b verr=%b rr=%b wr=%b rw=%b addr=%0d exp 0,00,0,0,1,0,0,0",
                  rdata_valid, rdata, done, verify_err, req_ready, wdata_ready, ram_rw, ram_addr);
      end
   endtask

   task automatic test_reset_mid_burst();
      issue(1'b1, 2'd0, 2'd3);
      @(negedge clk);
      wdata_valid = 1'b1; wdata = 8'h66;
      #1;
      @(negedge clk);
      wdata_valid = 1'b0;
      @(negedge clk);
      clr = 1'b1; wdata_valid = 1'b1; wdata = 8'h77;
      #1;
      checks++;
      if (ram_rw !== 1'b0) begin
         errors++; $display("FAIL clr_write_gate got rw=%b exp=0", ram_rw);
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      #1;
      checks++;
      if (rdata_valid !== 1'b0 || done !== 1'b0 || ram_rw !== 1'b0 || req_ready !== 1'b1 || wdata_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_mid_burst got rv=%b done=%b rw=%b rr=%b wr=%b exp 0,0,0,1,0",
                  rdata_valid, done, ram_rw, req_ready, wdata_ready);
      end
      checks++;
      if (mem[0] !== 8'h66 || mem[1] !== 8'h00) begin
         errors++; $display("FAIL clr_mem got m0=%h m1=%h exp m0=66 m1=00", mem[0], mem[1]);
      end
      wdata_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lc;
      int exp_lc;
`ifdef RAM_BURST_WRITE_VERIFY_EN
      exp_lc = 6;
`else
      exp_lc = 3;
`endif
      wr_burst(2'd0, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 16'h0000, lc);
      checks++;
      if (lc != exp_lc) begin
         errors++; $display("FAIL b2b_last_cycle got=%0d exp=%0d", lc, exp_lc);
      end
   endtask

   task automatic test_read_stall();
      rd_burst(2'd0, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}, 1, 3);
   endtask

   task automatic test_wrap();
      int lc;
      wr_burst(2'd3, 2'd1, {8'h00, 8'h00, 8'hBB, 8'hAA}, 1'b0, 16'h0000, lc);
      rd_burst(2'd3, 2'd1, {8'h00, 8'h00, 8'hBB, 8'hAA}, 9, 0);
   endtask

   task automatic test_write_gaps();
      int lc;
      wr_burst(2'd1, 2'd1, {8'h00, 8'h00, 8'hC2, 8'hC1}, 1'b1, 16'h0012, lc);
      checks++;
      if (lc != 4) begin
         errors++; $display("FAIL gap_last_cycle got=%0d exp=4", lc);
      end
      rd_burst(2'd1, 2'd1, {8'h00, 8'h00, 8'hC2, 8'hC1}, 9, 0);
   endtask

   task automatic test_write_verify();
      int lc;
      logic exp_err;
`ifdef RAM_BURST_WRITE_VERIFY_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      force_zero = 1'b0;
      wr_burst(2'd2, 2'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0, 16'h0000, lc);
      checks++;
      if (verify_err !== 1'b0) begin
         errors++; $display("FAIL verify_clean got=%b exp=0", verify_err);
      end
      force_zero = 1'b1;
      wr_burst(2'd2, 2'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0, 16'h0000, lc);
      force_zero = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (verify_err !== exp_err) begin
         errors++; $display("FAIL verify_sticky got=%b exp=%b", verify_err, exp_err);
      end
      rd_burst(2'd2, 2'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, 9, 0);
      checks++;
      if (verify_err !== 1'b0) begin
         errors++; $display("FAIL verify_clear got=%b exp=0", verify_err);
      end
   endtask

   initial begin
      clk = 1'b0; clr = 1'b1; mem_init = 1'b1; force_zero = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_len = 2'd0;
      wdata_valid = 1'b0; wdata = 8'h00; rdata_ready = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_reset_mid_burst();
      test_back_to_back();
      test_read_stall();
      test_wrap();
      test_write_gaps();
      test_write_verify();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Request-driven access sequencer sitting directly upstream of the 4x8 RAM built from two 2x8 halves. It accepts single or burst (1-4 beat) read/write requests over a valid/ready handshake and drives the RAM's R_W/ADDR/DATA_IN pins. It captures the RAM's combinational read data into a backpressured output register. It owns all RAM sequencing, so client logic never touches R_W timing directly.

Parameters:
AW, 2, RAM address width; the burst address wraps modulo 2^AW.
DW, 8, data width.

Ports:
CLK  in  1  clock; all state updates on posedge.
CLR  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_write  in  1  1=write burst, 0=read burst.
req_addr  in  AW  start address.
req_len  in  2  beats minus 1 (0 = 1 beat, 3 = 4 beats).
wdata_valid  in  1  write beat present.
wdata_ready  out  1  write beat accepted this cycle when valid.
wdata  in  DW  write beat data.
rdata_valid  out  1  read beat held in output register.
rdata_ready  in  1  consumer takes rdata this cycle.
rdata  out  DW  read beat.
done  out  1  one-cycle pulse after the last beat of a burst completes.
verify_err  out  1  sticky write-verify mismatch flag (see Optional Feature).
ram_rw  out  1  to RAM R_W: 1 = write on this posedge.
ram_addr  out  AW  to RAM ADDR.
ram_din  out  DW  to RAM DATA_IN.
ram_dout  in  DW  from RAM DATA_OUT; valid combinationally while ram_rw=0.

Behaviour:
- Reset (CLR high at posedge): state=IDLE, rdata_valid=0, rdata=0, done=0, verify_err=0, beat counter=0, cur_addr=0. Reset mid-burst abandons the burst; no further RAM write happens from that cycle on.
- States: IDLE, WRITE, READ (plus VERIFY when the optional feature is enabled).
- IDLE: req_ready = !rdata_valid. On req_valid&&req_ready, latch req_addr into cur_addr, req_len into remaining count, and direction, then go to WRITE or READ next cycle. ram_rw=0, ram_addr=0.
- WRITE: wdata_ready=1. ram_rw = wdata_valid (combinational), ram_addr=cur_addr, ram_din=wdata. Each accepted beat is written at that posedge, then cur_addr = cur_addr+1 mod 2^AW (3 wraps to 0). After the last beat: go to IDLE, done=1 for the next cycle. Cycles without wdata_valid insert idle gaps with no write.
- READ: ram_rw=0, ram_addr=cur_addr. Capture condition: !rdata_valid || rdata_ready. On capture, rdata<=ram_dout, rdata_valid<=1, and cur_addr increments with the same wrap rule. rdata stays stable while rdata_valid && !rdata_ready. On the last capture: go to IDLE and pulse done the next cycle. rdata_valid clears when taken with no new capture.
- Outside WRITE, ram_rw is never 1 and wdata_ready is 0.
- Latency: a read beat appears on rdata 1 cycle after READ is entered, then at 1 beat/cycle under rdata_ready=1. A write beat lands in RAM at the posedge where wdata_valid&&wdata_ready.
- A new request cannot be accepted while a read beat is still pending in the output register.

Optional Feature:
Macro RAM_BURST_WRITE_VERIFY_EN.
- Defined: after each accepted write beat, the controller enters VERIFY for one cycle with ram_rw=0, ram_addr = the just-written address and wdata_ready=0. It compares ram_dout with the stored beat; a mismatch sets verify_err, which holds until CLR or the next accepted request. Throughput drops to 1 beat per 2 cycles. cur_addr advances after VERIFY.
- Undefined: no VERIFY state, and verify_err is tied to 0.

Test Plan:
- CLR held 2 cycles mid write burst -> rdata_valid=0, done=0, ram_rw=0 the cycle after; req_ready=1.
- Write addr=0, len=3, data 11,22,33,44 back-to-back -> ram_rw high 4 consecutive cycles on addr 0,1,2,3; done pulses once.
- Write addr=3, len=1, data AA,BB, then read addr=3, len=1 -> rdata AA then BB (address wraps 3->0).
- Read addr=0, len=3 with rdata_ready low for 3 cycles on beat 2 -> rdata holds 22 stable, no beat lost or duplicated, req_ready=0 until the final beat is consumed.
- Write with wdata_valid gaps (valid on cycles 1,4) -> exactly 2 writes; no write occurs on the gap cycles.
- With RAM_BURST_WRITE_VERIFY_EN, force ram_dout=00 during VERIFY after writing 5A -> verify_err=1 sticky; it clears on the next accepted request.
